// File: rtl/uart_msg_pkg.sv
// Shared types, message indices and ASCII templates for the tic-tac-toe console printer.
// msg_byte() is the single source of template text; the ROM wraps it.
package uart_msg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam int unsigned MSG_RESULT_WIN  = 0;
  localparam int unsigned MSG_RESULT_DRAW = 1;
  localparam int unsigned MSG_TURN        = 2;
  localparam int unsigned MSG_ILLEGAL     = 3;

  localparam logic [7:0] CH_NUL = 8'h00;
  localparam logic [7:0] CH_ARG = 8'h01;

  // Every template is padded with NULs to this width, so index 0 is the leftmost byte.
  localparam int unsigned TPL_BYTES = 24;

  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  function automatic logic [7:0] msg_byte(input int unsigned sel, input int unsigned idx);
    logic [8*TPL_BYTES-1:0] tpl;
    case (sel)
      MSG_RESULT_WIN:  tpl = {"Game End: P", CH_ARG, " Win", 8'h0d, 8'h0a, {6{CH_NUL}}};
      MSG_RESULT_DRAW: tpl = {"Game End: Draw", 8'h0d, 8'h0a, {8{CH_NUL}}};
      MSG_TURN:        tpl = {"Turn: P", CH_ARG, 8'h0d, 8'h0a, {14{CH_NUL}}};
      MSG_ILLEGAL:     tpl = {"Illegal move", 8'h0d, 8'h0a, {10{CH_NUL}}};
      default:         tpl = '0;
    endcase
    if (idx >= TPL_BYTES) begin
      return CH_NUL;
    end
    tpl = tpl << (8 * idx);
    return tpl[8*TPL_BYTES-1 -: 8];
  endfunction

endpackage

// File: rtl/uart_msg_rom.sv
// Combinational template store: (sel, idx) -> template byte.
// Kept as its own block so it can later be swapped for a registered BRAM.
module uart_msg_rom #(
  parameter int SEL_W = 2,
  parameter int IDX_W = 5
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       data
);
  import uart_msg_pkg::*;

  always_comb begin
    data = msg_byte(32'(sel), 32'(idx));
  end

endmodule

// File: rtl/uart_msg_printer.sv
// Streams one NUL-terminated template to the UART TX, replacing CH_ARG bytes with
// the captured argument as a hex digit; supports abort and flags bad selects.
module uart_msg_printer
  import uart_msg_pkg::*;
#(
  parameter int NUM_MSG = 4,
  parameter int MAX_LEN = 24,
  localparam int SEL_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1,
  localparam int IDX_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [SEL_W-1:0] msg_sel,
  input  logic [3:0]       arg,
  input  logic             abort,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic             uart_wr,
  output logic [7:0]       uart_d,
  input  logic             uart_ready
);

  localparam logic [SEL_W:0]   NUM_MSG_W = (SEL_W + 1)'(NUM_MSG);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(MAX_LEN);

  state_t           state, state_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic [3:0]       arg_q, arg_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             invalid_q, invalid_n;
  logic             done_n, err_n, wr_n;
  logic [7:0]       d_n;
  logic [7:0]       rom_byte;

  uart_msg_rom #(
    .SEL_W(SEL_W),
    .IDX_W(IDX_W)
  ) u_rom (
    .sel (sel_q),
    .idx (idx_q),
    .data(rom_byte)
  );

  assign ready = (state == IDLE) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel_q     <= '0;
      arg_q     <= '0;
      idx_q     <= '0;
      invalid_q <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      uart_wr   <= 1'b0;
      uart_d    <= 8'h00;
    end else begin
      state     <= state_n;
      sel_q     <= sel_n;
      arg_q     <= arg_n;
      idx_q     <= idx_n;
      invalid_q <= invalid_n;
      done      <= done_n;
      err       <= err_n;
      uart_wr   <= wr_n;
      uart_d    <= d_n;
    end
  end

  // A rejected select finishes before abort is considered, so err always
  // accompanies its done pulse; otherwise abort beats emit, and the length
  // cap is checked before the template byte so idx never wraps.
  always_comb begin
    state_n   = state;
    sel_n     = sel_q;
    arg_n     = arg_q;
    idx_n     = idx_q;
    invalid_n = invalid_q;
    done_n    = 1'b0;
    err_n     = 1'b0;
    wr_n      = 1'b0;
    d_n       = uart_d;
    case (state)
      IDLE: begin
        if (req) begin
          sel_n     = msg_sel;
          arg_n     = arg;
          idx_n     = '0;
          invalid_n = ({1'b0, msg_sel} >= NUM_MSG_W);
          state_n   = SEND;
        end
      end
      SEND: begin
        if (invalid_q) begin
          done_n  = 1'b1;
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (abort) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (uart_ready) begin
          if ((idx_q == IDX_MAX) || (rom_byte == CH_NUL)) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            wr_n    = 1'b1;
            d_n     = (rom_byte == CH_ARG) ? hex_ascii(arg_q) : rom_byte;
            idx_n   = idx_q + IDX_W'(1);
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (abort) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = SEND;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_msg_printer.sv
// Directed bench for uart_msg_printer: a default instance for message content,
// timing, back-pressure and abort, and a small instance (NUM_MSG=5, MAX_LEN=8) for limits.
module tb_uart_msg_printer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance
  logic       req, abort, ready, done, err, uart_wr;
  logic       uart_ready = 1'b1;
  logic [1:0] msg_sel;
  logic [3:0] arg;
  logic [7:0] uart_d;

  // small instance
  logic       req2, abort2, ready2, done2, err2, wr2, uart_ready2;
  logic [2:0] sel2;
  logic [3:0] arg2;
  logic [7:0] d2;

  uart_msg_printer dut (
    .clk(clk), .reset(reset), .req(req), .msg_sel(msg_sel), .arg(arg),
    .abort(abort), .ready(ready), .done(done), .err(err),
    .uart_wr(uart_wr), .uart_d(uart_d), .uart_ready(uart_ready)
  );

  uart_msg_printer #(.NUM_MSG(5), .MAX_LEN(8)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .msg_sel(sel2), .arg(arg2),
    .abort(abort2), .ready(ready2), .done(done2), .err(err2),
    .uart_wr(wr2), .uart_d(d2), .uart_ready(uart_ready2)
  );

  // UART TX model: when stalling, drops ready for 5 cycles after each write
  bit stall_en = 1'b0;
  int busy     = 0;
  always @(negedge clk) begin
    if (!stall_en) begin
      uart_ready <= 1'b1;
      busy       <= 0;
    end else if (uart_wr) begin
      uart_ready <= 1'b0;
      busy       <= 5;
    end else if (busy > 1) begin
      busy <= busy - 1;
    end else if (busy == 1) begin
      busy       <= 0;
      uart_ready <= 1'b1;
    end
  end

  typedef struct {
    logic [1:0] sel;
    logic [3:0] arg;
    bit         stall;
    string      text;
  } vec_t;

  vec_t vecs[7];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue a request at the current negedge and collect the whole message.
  task automatic apply_stimulus(input logic [1:0] sel, input logic [3:0] a, input bit stall,
                                input string exp);
    logic [7:0] rx[$];
    int stamps[$];
    int c0, done_cyc, bad_gap, wr_busy;
    stall_en = stall;
    req      = 1'b1;
    msg_sel  = sel;
    arg      = a;
    c0       = cyc;
    done_cyc = -1;
    bad_gap  = 0;
    wr_busy  = 0;
    for (int n = 0; n < 600 && done_cyc < 0; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (n == 0) check_output("ready_fall", 32'(ready), 32'd0);
      if (uart_wr) begin
        rx.push_back(uart_d);
        stamps.push_back(cyc);
        if (!uart_ready) wr_busy++;
      end
      if (done) begin
        done_cyc = cyc;
        check_output("err_with_done", 32'(err), 32'd0);
        check_output("ready_at_done", 32'(ready), 32'd1);
      end
    end
    check_output("done_seen", 32'(done_cyc >= 0), 32'd1);
    check_output("strobe_count", 32'(rx.size()), 32'(exp.len()));
    for (int i = 0; i < rx.size() && i < exp.len(); i++) begin
      check_output($sformatf("byte%0d", i), 32'(rx[i]), 32'(exp[i]));
    end
    if (rx.size() > 0) begin
      check_output("first_strobe_cycle", 32'(stamps[0] - c0), 32'd2);
      if (!stall) begin
        for (int i = 1; i < stamps.size(); i++) begin
          if (stamps[i] - stamps[i-1] != 2) bad_gap++;
        end
        check_output("strobe_spacing", 32'(bad_gap), 32'd0);
        check_output("done_latency", 32'(done_cyc - stamps[stamps.size()-1]), 32'd2);
      end else begin
        check_output("wr_while_busy", 32'(wr_busy), 32'd0);
      end
    end
    stall_en = 1'b0;
    @(negedge clk);
    check_output("done_single", 32'(done), 32'd0);
    check_output("idle_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{sel: 2'd0, arg: 4'h2, stall: 1'b0, text: "Game End: P2 Win\r\n"};
    vecs[1] = '{sel: 2'd2, arg: 4'hB, stall: 1'b1, text: "Turn: PB\r\n"};
    vecs[2] = '{sel: 2'd1, arg: 4'h7, stall: 1'b0, text: "Game End: Draw\r\n"};
    vecs[3] = '{sel: 2'd3, arg: 4'h0, stall: 1'b1, text: "Illegal move\r\n"};
    vecs[4] = '{sel: 2'd2, arg: 4'h9, stall: 1'b0, text: "Turn: P9\r\n"};
    vecs[5] = '{sel: 2'd0, arg: 4'hF, stall: 1'b1, text: "Game End: PF Win\r\n"};
    vecs[6] = '{sel: 2'd2, arg: 4'hA, stall: 1'b0, text: "Turn: PA\r\n"};

    reset = 1'b1;
    req = 1'b0; abort = 1'b0; msg_sel = '0; arg = '0;
    req2 = 1'b0; abort2 = 1'b0; sel2 = '0; arg2 = '0; uart_ready2 = 1'b1;

    // reset values
    repeat (3) @(negedge clk);
    check_output("rst_ready", 32'(ready), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_wr", 32'(uart_wr), 32'd0);
    check_output("rst_d", 32'(uart_d), 32'd0);
    check_output("rst_ready2", 32'(ready2), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_output("post_rst_ready", 32'(ready), 32'd1);
    begin
      int idle_wr = 0;
      for (int n = 0; n < 5; n++) begin
        @(negedge clk);
        if (uart_wr || wr2) idle_wr++;
      end
      check_output("idle_no_strobe", 32'(idle_wr), 32'd0);
    end

    // table of full messages
    for (int v = 0; v < 7; v++) begin
      apply_stimulus(vecs[v].sel, vecs[v].arg, vecs[v].stall, vecs[v].text);
    end

    // abort after the third strobe of the draw message, then re-request in the done cycle
    begin
      string gam = "Gam";
      logic [7:0] rx[$];
      req = 1'b1; msg_sel = 2'd1; arg = 4'h0;
      for (int n = 0; n < 100 && rx.size() < 3; n++) begin
        @(negedge clk);
        req = 1'b0;
        if (uart_wr) rx.push_back(uart_d);
      end
      check_output("abort_prefix_count", 32'(rx.size()), 32'd3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_output("abort_no_wr", 32'(uart_wr), 32'd0);
      check_output("abort_done", 32'(done), 32'd1);
      check_output("abort_err", 32'(err), 32'd0);
      check_output("abort_ready", 32'(ready), 32'd1);
      for (int i = 0; i < rx.size() && i < 3; i++) begin
        check_output($sformatf("abort_byte%0d", i), 32'(rx[i]), 32'(gam[i]));
      end
      apply_stimulus(2'd2, 4'h1, 1'b0, "Turn: P1\r\n");
    end

    // invalid select on the NUM_MSG=5 instance
    begin
      int wr_cnt = 0;
      req2 = 1'b1; sel2 = 3'd5; arg2 = 4'h3;
      @(negedge clk);
      req2 = 1'b0;
      check_output("inv_c1_done", 32'(done2), 32'd0);
      check_output("inv_c1_ready", 32'(ready2), 32'd0);
      if (wr2) wr_cnt++;
      @(negedge clk);
      if (wr2) wr_cnt++;
      check_output("inv_c2_done", 32'(done2), 32'd1);
      check_output("inv_c2_err", 32'(err2), 32'd1);
      @(negedge clk);
      if (wr2) wr_cnt++;
      check_output("inv_c3_done", 32'(done2), 32'd0);
      check_output("inv_c3_ready", 32'(ready2), 32'd1);
      check_output("inv_strobes", 32'(wr_cnt), 32'd0);
    end

    // MAX_LEN=8 truncation of message 0
    begin
      string exp8 = "Game End";
      logic [7:0] rx[$];
      int last_wr = 0, done_cyc = -1;
      req2 = 1'b1; sel2 = 3'd0; arg2 = 4'h3;
      for (int n = 0; n < 100 && done_cyc < 0; n++) begin
        @(negedge clk);
        req2 = 1'b0;
        if (wr2) begin
          rx.push_back(d2);
          last_wr = cyc;
        end
        if (done2) done_cyc = cyc;
      end
      check_output("cap_count", 32'(rx.size()), 32'd8);
      for (int i = 0; i < rx.size() && i < 8; i++) begin
        check_output($sformatf("cap_byte%0d", i), 32'(rx[i]), 32'(exp8[i]));
      end
      check_output("cap_done_latency", 32'(done_cyc - last_wr), 32'd2);
      check_output("cap_err", 32'(err2), 32'd0);
    end

    // reset pulsed mid-message
    begin
      int seen = 0, after = 0;
      @(negedge clk);
      req2 = 1'b1; sel2 = 3'd0; arg2 = 4'h1;
      for (int n = 0; n < 50 && seen < 2; n++) begin
        @(negedge clk);
        req2 = 1'b0;
        if (wr2) seen++;
      end
      check_output("mid_prefix", 32'(seen), 32'd2);
      reset = 1'b1;
      #1;
      check_output("mid_rst_wr", 32'(wr2), 32'd0);
      check_output("mid_rst_d", 32'(d2), 32'd0);
      check_output("mid_rst_ready", 32'(ready2), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < 30; n++) begin
        @(negedge clk);
        if (wr2 || done2) after++;
      end
      check_output("mid_no_resume", 32'(after), 32'd0);
      check_output("mid_ready_back", 32'(ready2), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
